// File: rtl/pattern_encoder.sv
// Row-major sparse pattern to packed variable-length code stream encoder.
// Optional input order checking: define PATTERN_ENCODER_ORDER_CHECK_EN.
module pattern_encoder #(
    parameter int INDEX_WIDTH = 32,
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic                   index_push,
    input  logic [INDEX_WIDTH-1:0] row,
    input  logic [INDEX_WIDTH-1:0] col,
    output logic                   index_stall,
    input  logic                   finish,
    output logic                   wr_req,
    input  logic                   wr_stall,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   done,
`ifdef PATTERN_ENCODER_ORDER_CHECK_EN
    output logic                   error,
`endif
    output logic [ADDR_WIDTH-1:0]  word_count
);

    localparam int VW = INDEX_WIDTH + 1;
    localparam int LW = $clog2(VW + 1);
    localparam int BW = 2 * DATA_WIDTH;
    localparam int FW = $clog2(BW + 1);
    localparam int SH = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_COL2, S_FLUSH, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [BW-1:0]          buf_q, buf_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [INDEX_WIDTH-1:0] prow_q, prow_d;
    logic [VW-1:0]          pcol_q, pcol_d;
    logic [VW-1:0]          pend_q, pend_d;
    logic                   fin_q, fin_d;
    logic                   end_q, end_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

    logic          room, accept, row_up, bad;
    logic          emit_full, emit_part, emit;
    logic [VW-1:0] row_val, col_val, col_first;
    logic          app, app_t;
    logic [VW-1:0] app_v;

    function automatic logic [LW-1:0] bitlen(input logic [VW-1:0] v);
        logic [LW-1:0] n;
        n = '0;
        for (int i = 0; i < VW; i++)
            if (v[i]) n = LW'(i + 1);
        return n;
    endfunction

    // Code layout LSB-first: type, W, then exactly W value bits.
    function automatic logic [BW-1:0] mkcode(input logic t,
                                             input logic [VW-1:0] v);
        logic [BW-1:0] c;
        c = '0;
        c[0] = t;
        c[LW:1] = bitlen(v);
        c[LW+VW:LW+1] = v;
        return c;
    endfunction

    function automatic logic [FW-1:0] codelen(input logic [VW-1:0] v);
        return FW'(LW + 1) + FW'(bitlen(v));
    endfunction

    assign room      = fill_q < FW'(DATA_WIDTH);
    assign accept    = (state_q == S_RUN) && room && index_push;
    assign row_up    = row > prow_q;
    assign row_val   = {1'b0, row} - {1'b0, prow_q};
    assign col_val   = {1'b0, col} - pcol_q;
    assign col_first = {1'b0, col} + VW'(1);
    assign emit_full = !room;
    // The trailing partial word only goes out once the end code is in.
    assign emit_part = (state_q == S_FLUSH) && end_q
                    && (fill_q != '0) && room;
    assign emit      = (emit_full || emit_part) && !wr_stall;

`ifdef PATTERN_ENCODER_ORDER_CHECK_EN
    // prev_col starts at -1, so the column test is a signed compare.
    assign bad = (row < prow_q)
              || ((row == prow_q)
                  && ($signed({1'b0, col}) <= $signed(pcol_q)));

    logic err_q;

    // Sticky order error, cleared when a new stream begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (state_q == S_IDLE && start)
            err_q <= 1'b0;
        else if (accept && bad)
            err_q <= 1'b1;
    end

    assign error = err_q;
`else
    assign bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a finish arriving with a row change waits for COL2.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (accept && !bad && row_up) state_d = S_COL2;
                else if (finish)              state_d = S_FLUSH;
            end
            S_COL2:  if (room) state_d = fin_q ? S_FLUSH : S_RUN;
            S_FLUSH: if (end_q && fill_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; nothing is accepted while in reset.
    always_comb begin
        index_stall = !rst && !((state_q == S_RUN) && room);
        done        = (state_q == S_DONE);
    end

    // Datapath: choose the code to append, or emit a word.
    always_comb begin
        buf_d     = buf_q;
        fill_d    = fill_q;
        prow_d    = prow_q;
        pcol_d    = pcol_q;
        pend_d    = pend_q;
        fin_d     = fin_q;
        end_d     = end_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        wr_req_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        app       = 1'b0;
        app_t     = 1'b0;
        app_v     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    buf_d  = '0;
                    fill_d = '0;
                    prow_d = '0;
                    pcol_d = '1;
                    fin_d  = 1'b0;
                    end_d  = 1'b0;
                    base_d = start_addr;
                    cnt_d  = '0;
                end
            end
            S_RUN: begin
                if (accept && !bad) begin
                    prow_d = row;
                    pcol_d = {1'b0, col};
                    app    = 1'b1;
                    if (row_up) begin
                        app_t  = 1'b1;
                        app_v  = row_val;
                        pend_d = col_first;
                        fin_d  = finish;
                    end else begin
                        app_v = col_val;
                    end
                end
            end
            S_COL2: begin
                if (room) begin
                    app   = 1'b1;
                    app_v = pend_q;
                end
            end
            S_FLUSH: begin
                if (!end_q && room) begin
                    app   = 1'b1;
                    app_t = 1'b1;
                    end_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (app) begin
            buf_d  = buf_q | (mkcode(app_t, app_v) << fill_q);
            fill_d = fill_q + codelen(app_v);
        end
        if (emit) begin
            wr_req_d  = 1'b1;
            wr_data_d = buf_q[DATA_WIDTH-1:0];
            wr_addr_d = base_q + (cnt_q << SH);
            buf_d     = buf_q >> DATA_WIDTH;
            fill_d    = emit_full ? fill_q - FW'(DATA_WIDTH) : '0;
            cnt_d     = cnt_q + ADDR_WIDTH'(1);
        end
    end

    // Datapath registers; reset aborts any stream in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q     <= '0;
            fill_q    <= '0;
            prow_q    <= '0;
            pcol_q    <= '1;
            pend_q    <= '0;
            fin_q     <= 1'b0;
            end_q     <= 1'b0;
            base_q    <= '0;
            cnt_q     <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            prow_q    <= prow_d;
            pcol_q    <= pcol_d;
            pend_q    <= pend_d;
            fin_q     <= fin_d;
            end_q     <= end_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_req     = wr_req_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_pattern_encoder.sv
// Directed testbench for pattern_encoder.
// Expected code words are hand-encoded constants.
module tb_pattern_encoder;

    logic        clk, rst, start, index_push, finish, wr_stall;
    logic [47:0] start_addr, wr_addr, word_count;
    logic [31:0] row, col;
    logic        index_stall, wr_req, done;
    logic [63:0] wr_data;
`ifdef PATTERN_ENCODER_ORDER_CHECK_EN
    logic        error;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [63:0] wq_data[$];
    logic [47:0] wq_addr[$];

    pattern_encoder dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .index_push(index_push), .row(row), .col(col),
        .index_stall(index_stall), .finish(finish),
        .wr_req(wr_req), .wr_stall(wr_stall), .wr_addr(wr_addr),
        .wr_data(wr_data), .done(done),
`ifdef PATTERN_ENCODER_ORDER_CHECK_EN
        .error(error),
`endif
        .word_count(word_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (wr_req) begin
            wq_data.push_back(wr_data);
            wq_addr.push_back(wr_addr);
        end
        if (done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (index_stall && n < 100) begin
            tick;
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL ready_wait: index_stall=%0b want 0", index_stall);
        end
    endtask

    task automatic push_pair(input logic [31:0] r, input logic [31:0] c,
                             input logic fin);
        wait_ready;
        index_push = 1; row = r; col = c; finish = fin;
        tick;
        index_push = 0; finish = 0;
    endtask

    task automatic do_finish;
        wait_ready;
        finish = 1;
        tick;
        finish = 0;
    endtask

    task automatic do_start(input logic [47:0] a);
        start_addr = a; start = 1;
        tick;
        start = 0;
    endtask

    task automatic wait_done;
        int d0, n;
        d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < 300) begin
            tick;
            n++;
        end
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL done_wait: no done pulse within 300 cycles");
        end
    endtask

    // Column code 0x1_0000_0000 (W=33) is 40'h80_0000_0042;
    // row delta 1 (W=1) is 8'h83; end code is 7'h01.
    function automatic logic [255:0] max_stream(input int nrows);
        logic [255:0] e;
        int p;
        e = '0; p = 0;
        e |= 256'(40'h80_0000_0042) << p; p += 40;
        for (int k = 0; k < nrows; k++) begin
            e |= 256'(8'h83) << p; p += 8;
            e |= 256'(40'h80_0000_0042) << p; p += 40;
        end
        e |= 256'(1) << p;
        return e;
    endfunction

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (wr_req !== 0 || wr_addr !== 0 || wr_data !== 0 || done !== 0
            || word_count !== 0 || index_stall !== 0) begin
            bad++;
            $display("FAIL reset_outs: req=%0b addr=%h data=%h done=%0b cnt=%0d stall=%0b want all 0",
                     wr_req, wr_addr, wr_data, done, word_count, index_stall);
        end
        rst = 0;
        tick;
        total++;
        if (index_stall !== 1) begin
            bad++;
            $display("FAIL idle_stall: got %0b want 1", index_stall);
        end
    endtask

    task automatic test_basic;
        int qb, d0;
        qb = wq_data.size(); d0 = done_cnt;
        do_start(48'h100);
        total++;
        if (index_stall !== 0) begin
            bad++;
            $display("FAIL run_stall: got %0b want 0", index_stall);
        end
        push_pair(0, 0, 0);
        start_addr = 48'h900; start = 1;
        tick;
        start = 0;
        push_pair(0, 3, 0);
        do_finish;
        wait_done;
        total++;
        if (wq_data.size() - qb != 1) begin
            bad++;
            $display("FAIL basic_nwords: got %0d want 1", wq_data.size() - qb);
        end else begin
            total++;
            if (wq_addr[qb] !== 48'h100 || wq_data[qb] !== 64'h38482) begin
                bad++;
                $display("FAIL basic_word: got %h@%h want 38482@100",
                         wq_data[qb], wq_addr[qb]);
            end
        end
        total++;
        if (word_count !== 1 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL basic_count: cnt=%0d dones=%0d want 1 1",
                     word_count, done_cnt - d0);
        end
    endtask

    task automatic test_row_change;
        int qb;
        qb = wq_data.size();
        do_start(48'h0);
        push_pair(2, 5, 0);
        total++;
        if (index_stall !== 1) begin
            bad++;
            $display("FAIL col2_stall: got %0b want 1", index_stall);
        end
        tick;
        total++;
        if (index_stall !== 0) begin
            bad++;
            $display("FAIL col2_release: got %0b want 0", index_stall);
        end
        do_finish;
        wait_done;
        total++;
        if (wq_data.size() - qb != 1) begin
            bad++;
            $display("FAIL row_nwords: got %0d want 1", wq_data.size() - qb);
        end else begin
            total++;
            if (wq_addr[qb] !== 48'h0 || wq_data[qb] !== 64'hE0D05) begin
                bad++;
                $display("FAIL row_word: got %h@%h want e0d05@0",
                         wq_data[qb], wq_addr[qb]);
            end
        end
    endtask

    task automatic test_push_finish;
        int qb;
        qb = wq_data.size();
        do_start(48'h500);
        push_pair(0, 0, 1);
        wait_done;
        total++;
        if (wq_data.size() - qb != 1) begin
            bad++;
            $display("FAIL pf_nwords: got %0d want 1", wq_data.size() - qb);
        end else begin
            total++;
            if (wq_addr[qb] !== 48'h500 || wq_data[qb] !== 64'h182) begin
                bad++;
                $display("FAIL pf_word: got %h@%h want 182@500",
                         wq_data[qb], wq_addr[qb]);
            end
        end
    endtask

    task automatic test_max_codes;
        int qb, pos, w, nd;
        logic [255:0] e, s;
        logic t, after_row;
        longint v, r, c;
        qb = wq_data.size();
        e = max_stream(4);
        do_start(48'h0);
        for (int k = 0; k < 5; k++) push_pair(k, 32'hFFFF_FFFF, 0);
        do_finish;
        wait_done;
        total++;
        if (wq_data.size() - qb != 4 || word_count !== 4) begin
            bad++;
            $display("FAIL max_nwords: got %0d cnt=%0d want 4 4",
                     wq_data.size() - qb, word_count);
        end else begin
            s = '0;
            for (int i = 0; i < 4; i++) begin
                s[64*i +: 64] = wq_data[qb+i];
                total++;
                if (wq_data[qb+i] !== e[64*i +: 64]
                    || wq_addr[qb+i] !== 48'(8*i)) begin
                    bad++;
                    $display("FAIL max_word%0d: got %h@%h want %h@%h", i,
                             wq_data[qb+i], wq_addr[qb+i], e[64*i +: 64], 8*i);
                end
            end
            r = 0; c = -1; pos = 0; nd = 0; after_row = 0;
            for (int it = 0; it < 20; it++) begin
                t = s[pos];
                w = 0;
                for (int b = 0; b < 6; b++) w |= int'(s[pos+1+b]) << b;
                v = 0;
                for (int b = 0; b < w; b++) v |= longint'(s[pos+7+b]) << b;
                pos += 7 + w;
                if (t && w == 0) break;
                if (t) begin
                    r += v; after_row = 1;
                end else begin
                    c = after_row ? v - 1 : c + v;
                    after_row = 0;
                    total++;
                    if (r != longint'(nd) || c != 64'hFFFF_FFFF) begin
                        bad++;
                        $display("FAIL decode_pair%0d: got (%0d,%h) want (%0d,ffffffff)",
                                 nd, r, c, nd);
                    end
                    nd++;
                end
            end
            total++;
            if (nd != 5) begin
                bad++;
                $display("FAIL decode_count: got %0d want 5", nd);
            end
        end
    endtask

    task automatic test_wr_stall;
        int qb;
        logic [255:0] e;
        qb = wq_data.size();
        e = max_stream(1);
        wr_stall = 1;
        do_start(48'h200);
        push_pair(0, 32'hFFFF_FFFF, 0);
        push_pair(1, 32'hFFFF_FFFF, 0);
        tick;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (wr_req !== 0 || index_stall !== 1) begin
                bad++;
                $display("FAIL stall_hold%0d: req=%0b stall=%0b want 0 1",
                         i, wr_req, index_stall);
            end
            tick;
        end
        wr_stall = 0;
        do_finish;
        wait_done;
        total++;
        if (wq_data.size() - qb != 2) begin
            bad++;
            $display("FAIL stall_nwords: got %0d want 2", wq_data.size() - qb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (wq_data[qb+i] !== e[64*i +: 64]
                    || wq_addr[qb+i] !== 48'(48'h200 + 8*i)) begin
                    bad++;
                    $display("FAIL stall_word%0d: got %h@%h want %h@%h", i,
                             wq_data[qb+i], wq_addr[qb+i], e[64*i +: 64],
                             48'h200 + 8*i);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int n, qb;
        do_start(48'h300);
        push_pair(0, 32'hFFFF_FFFF, 0);
        push_pair(1, 32'hFFFF_FFFF, 0);
        n = 0;
        while (!wr_req && n < 50) begin
            tick;
            n++;
        end
        total++;
        if (!wr_req) begin
            bad++;
            $display("FAIL mid_wr: got req=0 want 1 before reset");
        end
        rst = 1;
        #1;
        total++;
        if (wr_req !== 0 || wr_addr !== 0 || wr_data !== 0 || done !== 0
            || word_count !== 0 || index_stall !== 0) begin
            bad++;
            $display("FAIL mid_reset: req=%0b addr=%h data=%h cnt=%0d stall=%0b want all 0",
                     wr_req, wr_addr, wr_data, word_count, index_stall);
        end
        tick;
        rst = 0;
        tick;
        qb = wq_data.size();
        do_start(48'h400);
        total++;
        if (word_count !== 0) begin
            bad++;
            $display("FAIL restart_cnt: got %0d want 0", word_count);
        end
        push_pair(0, 0, 0);
        push_pair(0, 3, 0);
        do_finish;
        wait_done;
        total++;
        if (wq_data.size() - qb != 1) begin
            bad++;
            $display("FAIL restart_nwords: got %0d want 1", wq_data.size() - qb);
        end else begin
            total++;
            if (wq_addr[qb] !== 48'h400 || wq_data[qb] !== 64'h38482
                || word_count !== 1) begin
                bad++;
                $display("FAIL restart_word: got %h@%h cnt=%0d want 38482@400 1",
                         wq_data[qb], wq_addr[qb], word_count);
            end
        end
    endtask

    task automatic test_idle_ignore;
        int qb, d0;
        qb = wq_data.size(); d0 = done_cnt;
        finish = 1; index_push = 1; row = 7; col = 7;
        tick;
        finish = 0; index_push = 0;
        repeat (4) tick;
        total++;
        if (wq_data.size() != qb || done_cnt != d0 || index_stall !== 1) begin
            bad++;
            $display("FAIL idle_ignore: words=%0d dones=%0d stall=%0b want 0 0 1",
                     wq_data.size() - qb, done_cnt - d0, index_stall);
        end
    endtask

`ifdef PATTERN_ENCODER_ORDER_CHECK_EN
    task automatic test_order_check;
        int qb;
        qb = wq_data.size();
        do_start(48'h600);
        total++;
        if (error !== 0) begin
            bad++;
            $display("FAIL err_init: got %0b want 0", error);
        end
        push_pair(3, 4, 0);
        push_pair(3, 4, 0);
        total++;
        if (error !== 1) begin
            bad++;
            $display("FAIL err_set: got %0b want 1", error);
        end
        do_finish;
        wait_done;
        total++;
        if (wq_data.size() - qb != 1 || wq_data[qb] !== 64'hD0D85) begin
            bad++;
            $display("FAIL err_stream: nwords=%0d want 1 data d0d85",
                     wq_data.size() - qb);
        end
        do_start(48'h0);
        total++;
        if (error !== 0) begin
            bad++;
            $display("FAIL err_clear: got %0b want 0", error);
        end
        do_finish;
        wait_done;
    endtask
`endif

    initial begin
        rst = 1; start = 0; start_addr = '0; index_push = 0;
        row = '0; col = '0; finish = 0; wr_stall = 0;
        test_reset;
        test_basic;
        test_row_change;
        test_push_finish;
        test_max_codes;
        test_wr_stall;
        test_reset_mid;
        test_idle_ignore;
`ifdef PATTERN_ENCODER_ORDER_CHECK_EN
        test_order_check;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
